// File: rtl/sbrm_pkg.sv
// Shared HC-SR04 link definitions: FSM encoding, timing defaults and clock-rate helpers,
// common to the echo emulator and the ultrasonic initiator.
package sbrm_pkg;

  localparam int unsigned HC_CLK_FREQ_HZ   = 50_000_000;
  localparam int unsigned HC_DIST_W        = 12;
  localparam int unsigned HC_TRIG_MIN_US   = 10;
  localparam int unsigned HC_TURNAROUND_US = 250;
  localparam int unsigned HC_US_PER_CM     = 58;
  localparam int unsigned HC_MAX_CM        = 400;
  localparam int unsigned HC_TIMEOUT_US    = 38000;
  localparam int unsigned HC_HOLDOFF_US    = 1000;
  localparam int unsigned US_CNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  function automatic int unsigned clks_per_us(input int unsigned clk_freq_hz);
    return (clk_freq_hz < 1_000_000) ? 1 : clk_freq_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLKS_PER_US clocks, realigned by restart_i so
// a freshly entered state always gets a full first microsecond.
module us_tick_gen #(
  parameter int unsigned CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_US - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: validates a trigger pulse, waits the acoustic turnaround, then returns an
// echo whose width encodes the programmed distance, followed by a dead time.
module hcsr04_echo_emulator
  import sbrm_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = HC_CLK_FREQ_HZ,
  parameter int unsigned DIST_W        = HC_DIST_W,
  parameter int unsigned TRIG_MIN_US   = HC_TRIG_MIN_US,
  parameter int unsigned TURNAROUND_US = HC_TURNAROUND_US,
  parameter int unsigned US_PER_CM     = HC_US_PER_CM,
  parameter int unsigned MAX_CM        = HC_MAX_CM,
  parameter int unsigned TIMEOUT_US    = HC_TIMEOUT_US,
  parameter int unsigned HOLDOFF_US    = HC_HOLDOFF_US
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] distance_cm,
  output logic              echo,
  output logic              busy,
  output logic              trig_err,
  output logic              out_of_range
);

  localparam int unsigned CLKS_PER_US  = clks_per_us(CLK_FREQ_HZ);
  localparam int unsigned TRIG_MIN_CYC = TRIG_MIN_US * CLKS_PER_US;
  localparam int unsigned HI_W         = $clog2(TRIG_MIN_CYC + 1);
  localparam int unsigned PROD_W       = DIST_W + 7;
  localparam logic [HI_W-1:0] HI_MAX   = HI_W'(TRIG_MIN_CYC);

  state_e                state_q, state_d;
  logic                  trig_meta_q, trig_s_q, trig_prev_q;
  logic [HI_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
  logic [US_CNT_W-1:0]   width_q, width_d;
  logic                  oor_q, oor_d;
  logic                  trig_err_q, trig_err_d;
  logic                  echo_q;
  logic                  tick;
  logic                  trig_rise;
  logic                  last_us;
  logic                  in_range;
  logic [PROD_W-1:0]     prod;
  logic [US_CNT_W-1:0]   width_calc;

  assign trig_rise  = trig_s_q && !trig_prev_q;
  assign last_us    = tick && (us_cnt_q == US_CNT_W'(1));
  assign prod       = PROD_W'(distance_cm) * PROD_W'(US_PER_CM);
  assign in_range   = (distance_cm != '0) && (32'(distance_cm) <= MAX_CM);
  assign width_calc = in_range ? US_CNT_W'(prod) : US_CNT_W'(TIMEOUT_US);

  us_tick_gen #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart_i(state_d != state_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    us_cnt_d   = us_cnt_q;
    width_d    = width_q;
    oor_d      = oor_q;
    trig_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The rise cycle itself counts, so a pulse of exactly TRIG_MIN_US is accepted.
        if (trig_rise) begin
          state_d  = ST_TRIG_HI;
          hi_cnt_d = HI_W'(1);
        end
      end
      ST_TRIG_HI: begin
        if (trig_s_q) begin
          if (hi_cnt_q != HI_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
        end else if (hi_cnt_q < HI_MAX) begin
          trig_err_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          width_d  = width_calc;
          oor_d    = !in_range;
          us_cnt_d = US_CNT_W'(TURNAROUND_US);
          state_d  = ST_BURST;
        end
      end
      ST_BURST: begin
        if (last_us) begin
          us_cnt_d = width_q;
          state_d  = ST_ECHO;
        end else if (tick) begin
          us_cnt_d = us_cnt_q - 1'b1;
        end
      end
      ST_ECHO: begin
        if (last_us) begin
          us_cnt_d = US_CNT_W'(HOLDOFF_US);
          state_d  = ST_HOLDOFF;
        end else if (tick) begin
          us_cnt_d = us_cnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (last_us) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          us_cnt_d = us_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      hi_cnt_q    <= '0;
      us_cnt_q    <= '0;
      width_q     <= '0;
      oor_q       <= 1'b0;
      trig_err_q  <= 1'b0;
      echo_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_meta_q <= trig;
      trig_s_q    <= trig_meta_q;
      trig_prev_q <= trig_s_q;
      hi_cnt_q    <= hi_cnt_d;
      us_cnt_q    <= us_cnt_d;
      width_q     <= width_d;
      oor_q       <= oor_d;
      trig_err_q  <= trig_err_d;
      echo_q      <= (state_d == ST_ECHO);
    end
  end

  assign echo         = echo_q;
  assign busy         = (state_q != ST_IDLE);
  assign trig_err     = trig_err_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Randomized scoreboard bench for hcsr04_echo_emulator, scaled-down timing for short runs.
module tb_hcsr04_echo_emulator;

  localparam int CLK_HZ = 2_000_000;
  localparam int CPU    = 2;
  localparam int TMIN   = 10;
  localparam int TURN   = 25;
  localparam int USPC   = 3;
  localparam int MAXCM  = 40;
  localparam int TOUT   = 150;
  localparam int HOLD   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic [11:0] distance_cm;
  logic        echo, busy, trig_err, out_of_range;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    bit is_err;
    bit abort;
    bit oor;
    int rise_cyc;
    int fall_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_e, ev;
  bit   echo_prev = 1'b0;
  bit   in_echo = 1'b0;

  hcsr04_echo_emulator #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .DIST_W       (12),
    .TRIG_MIN_US  (TMIN),
    .TURNAROUND_US(TURN),
    .US_PER_CM    (USPC),
    .MAX_CM       (MAXCM),
    .TIMEOUT_US   (TOUT),
    .HOLDOFF_US   (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig        (trig),
    .distance_cm (distance_cm),
    .echo        (echo),
    .busy        (busy),
    .trig_err    (trig_err),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit model_in_range(input int d);
    return (d >= 1) && (d <= MAXCM);
  endfunction

  function automatic int model_width_us(input int d);
    return model_in_range(d) ? d * USPC : TOUT;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // mode 0: plain, 1: disturb during echo/holdoff, 2: reset mid-echo
  task automatic run_txn(input int d, input int h, input int mode);
    exp_t e;
    int n, w_cyc, end_cyc, k;
    @(negedge clk);
    distance_cm = 12'(d);
    trig = 1'b1;
    repeat (h) @(negedge clk);
    trig = 1'b0;
    n = cyc;
    $display("txn d=%0d trig_cycles=%0d mode=%0d fall_cyc=%0d", d, h, mode, n);
    e.is_err = 1'b0; e.abort = 1'b0; e.oor = 1'b0; e.rise_cyc = 0; e.fall_cyc = 0;
    if (h < TMIN * CPU) begin
      e.is_err = 1'b1;
      e.rise_cyc = n + 3;
      exp_q.push_back(e);
      wait_until(n + 6);
      return;
    end
    w_cyc = model_width_us(d) * CPU;
    e.oor = !model_in_range(d);
    e.rise_cyc = n + 3 + TURN * CPU;
    if (mode == 2) begin
      k = $urandom_range(0, w_cyc - 2);
      e.abort = 1'b1;
      e.fall_cyc = e.rise_cyc + k + 1;
      exp_q.push_back(e);
      wait_until(e.rise_cyc + k);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      return;
    end
    e.fall_cyc = e.rise_cyc + w_cyc;
    end_cyc = e.fall_cyc + HOLD * CPU;
    exp_q.push_back(e);
    if (mode == 1) begin
      wait_until(e.rise_cyc + 1);
      distance_cm = 12'($urandom_range(0, 45));
      trig = 1'b1;
      repeat (2) @(negedge clk);
      trig = 1'b0;
      wait_until(e.fall_cyc + 2);
      trig = 1'b1;
      wait_until(end_cyc + 3);
      trig = 1'b0;
      wait_until(end_cyc + 6);
    end else begin
      wait_until(end_cyc + 2);
    end
  endtask

  // Monitor: pops one expectation per trig_err cycle or echo pulse.
  always @(negedge clk) begin
    if (trig_err) begin
      if (exp_q.size() == 0) chk("trig_err_unexpected", 1, 0);
      else begin
        ev = exp_q.pop_front();
        chk("trig_err_kind", ev.is_err, 1);
        chk("trig_err_cycle", cyc, ev.rise_cyc);
        chk("busy_after_err", busy, 0);
      end
    end
    if (echo && !echo_prev) begin
      if (exp_q.size() == 0) chk("echo_unexpected", 1, 0);
      else begin
        ev = exp_q.pop_front();
        cur_e = ev;
        in_echo = 1'b1;
        chk("echo_kind", ev.is_err, 0);
        chk("echo_rise_cycle", cyc, ev.rise_cyc);
        chk("out_of_range", out_of_range, ev.oor);
        chk("busy_in_echo", busy, 1);
      end
    end
    if (!echo && echo_prev && in_echo) begin
      chk("echo_fall_cycle", cyc, cur_e.fall_cyc);
      chk("busy_after_echo", busy, cur_e.abort ? 0 : 1);
      in_echo = 1'b0;
    end
    echo_prev = echo;
  end

  int dir_d[12] = '{10, 40, 41, 0, 1, 4095, 20, 20, 30, 25, 15, 33};
  int dir_h[12] = '{20, 20, 20, 20, 25, 30, 19, 5, 30, 30, 20, 40};
  int dir_m[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1};

  initial begin
    int d, h, m;
    rst = 1'b1;
    trig = 1'b0;
    distance_cm = '0;
    repeat (3) @(negedge clk);
    chk("reset_echo", echo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_trig_err", trig_err, 0);
    chk("reset_oor", out_of_range, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 12; i++) run_txn(dir_d[i], dir_h[i], dir_m[i]);
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 45);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 19) : $urandom_range(20, 40);
      m = $urandom_range(0, 2);
      run_txn(d, h, m);
    end
    repeat (20) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("echo_closed", in_echo, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    chk("watchdog_expired", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
